// File: rtl/arith_engine_seq_if.sv
// Handshake/result bus of the arithmetic engine.
//   master: operand producer and result consumer (drives in_valid/in1/in2/op/out_ready)
//   slave : the engine (drives in_ready, out, flags, err, busy)
interface arith_engine_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             err;
    logic             busy;

    modport master (
        output in_valid, in1, in2, op, out_ready,
        input  in_ready, out_valid, out, flag_z, flag_c, flag_v, err, busy
    );

    modport slave (
        input  in_valid, in1, in2, op, out_ready,
        output in_ready, out_valid, out, flag_z, flag_c, flag_v, err, busy
    );
endinterface

// File: rtl/arith_engine_seq.sv
// Single-entry handshaked arithmetic engine: OR/NAND/NOR/AND, ADD/SUB, logical
// shifts, and an iterative shift-add multiply (one multiplier bit per cycle).
// Results and status flags are registered and held until the consumer takes them.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - arith_engine_seq_if.slave: operand handshake in, result/flags out
module arith_engine_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    arith_engine_seq_if.slave  bus
);
    localparam int                 CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   W_VAL    = WIDTH[WIDTH-1:0];
    localparam logic [3:0]         OP_MUL   = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_out;
    logic               r_z, r_c, r_v, r_err, r_busy, r_out_valid;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_accept;
    logic [WIDTH:0]     w_sum, w_dif, w_shl, w_shr;
    logic [WIDTH-1:0]   w_res;
    logic               w_c, w_v, w_err;
    logic [2*WIDTH-1:0] w_acc_nxt;

    // In HOLD the slot frees exactly when the current result is taken.
    assign bus.in_ready = (r_state == S_IDLE) | ((r_state == S_HOLD) & bus.out_ready);
    assign w_accept     = bus.in_valid & bus.in_ready;

    assign w_sum = {1'b0, bus.in1} + {1'b0, bus.in2};
    assign w_dif = {1'b0, bus.in1} - {1'b0, bus.in2};
    // Extra bit on the far side of each shift catches the last bit shifted out;
    // amount 0 leaves that bit 0, so no special case is needed.
    assign w_shl = {1'b0, bus.in1} << bus.in2;
    assign w_shr = {bus.in1, 1'b0} >> bus.in2;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (bus.op)
            4'd0: w_res = bus.in1 | bus.in2;
            4'd1: w_res = ~(bus.in1 & bus.in2);
            4'd2: w_res = ~(bus.in1 | bus.in2);
            4'd3: w_res = bus.in1 & bus.in2;
            4'd4: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) &
                        (w_sum[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            4'd5: begin
                w_res = w_dif[WIDTH-1:0];
                w_c   = w_dif[WIDTH];
                w_v   = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) &
                        (w_dif[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            4'd6: if (bus.in2 < W_VAL) begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            4'd7: if (bus.in2 < W_VAL) begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_MUL: ;  // handled by the iterative datapath
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out       <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_accept) begin
                        if (bus.op == OP_MUL) begin
                            r_state     <= S_MUL;
                            r_busy      <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_cnt       <= '0;
                            r_acc       <= '0;
                            r_mcand     <= {{WIDTH{1'b0}}, bus.in1};
                            r_mplier    <= bus.in2;
                        end else begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                            r_out       <= w_res;
                            r_z         <= ~w_err & (w_res == '0);
                            r_c         <= w_c;
                            r_v         <= w_v;
                            r_err       <= w_err;
                        end
                    end else if (r_state == S_HOLD && bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    // Last partial product folds straight into the result register.
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= S_HOLD;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out       <= w_acc_nxt[WIDTH-1:0];
                        r_z         <= (w_acc_nxt[WIDTH-1:0] == '0);
                        r_c         <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                        r_v         <= 1'b0;
                        r_err       <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out       = r_out;
    assign bus.flag_z    = r_z;
    assign bus.flag_c    = r_c;
    assign bus.flag_v    = r_v;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
endmodule
